// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared 4-bit 2:1 mux path.
// A grant is held while its owner keeps requesting. If the other side is
// waiting, the grant is preempted after HOLD_CYCLES consecutive cycles.
// The selected data is registered onto bus_out, qualified by bus_valid.
module mux2_rr_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [3:0] data_a,
  input  logic [3:0] data_b,
  output logic       grant_a,
  output logic       grant_b,
  output logic       sel,
  output logic [3:0] bus_out,
  output logic       bus_valid
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntA = 2'd1,
    StGntB = 2'd2
  } state_e;

  // Last tenure cycle before a waiting requester takes over.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Owner of the most recent grant: 0 = A, 1 = B.
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic [3:0]       bus_out_q, bus_out_d;
  logic             bus_valid_q, bus_valid_d;
  logic             enter_grant;

  // Next-state arbitration, tenure counting and mux-select tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;

    unique case (state_q)
      StIdle: begin
        if (req_a && req_b) begin
          state_d = last_q ? StGntA : StGntB;
        end else if (req_a) begin
          state_d = StGntA;
        end else if (req_b) begin
          state_d = StGntB;
        end
      end
      StGntA: begin
        if (!req_a) begin
          state_d = req_b ? StGntB : StIdle;
        end else if (req_b && (cnt_q == CntMax)) begin
          state_d = StGntB;
        end
      end
      StGntB: begin
        if (!req_b) begin
          state_d = req_a ? StGntA : StIdle;
        end else if (req_a && (cnt_q == CntMax)) begin
          state_d = StGntA;
        end
      end
      default: state_d = StIdle;
    endcase

    enter_grant = (state_d != StIdle) && (state_d != state_q);

    if (enter_grant) begin
      cnt_d  = '0;
      last_d = (state_d == StGntB);
      sel_d  = (state_d == StGntB);
    end else if (state_q != StIdle) begin
      // Saturate so a lone requester keeps the grant indefinitely.
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // Datapath: capture the selected source only while a grant is active.
  always_comb begin
    bus_out_d   = bus_out_q;
    bus_valid_d = (state_q != StIdle);
    if (state_q != StIdle) begin
      bus_out_d = sel_q ? data_b : data_a;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      bus_out_q   <= 4'h0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  assign grant_a   = (state_q == StGntA);
  assign grant_b   = (state_q == StGntB);
  assign sel       = sel_q;
  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a HOLD_CYCLES=4 instance and a
// HOLD_CYCLES=1 instance share clock, reset and request inputs.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst, req_a, req_b;
  logic [3:0] data_a, data_b;

  logic       ga0, gb0, sel0, val0;
  logic [3:0] bus0;
  logic       ga1, gb1, sel1, val1;
  logic [3:0] bus1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.HOLD_CYCLES(4), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .grant_a(ga0), .grant_b(gb0), .sel(sel0), .bus_out(bus0), .bus_valid(val0)
  );

  mux2_rr_arbiter #(.HOLD_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .grant_a(ga1), .grant_b(gb1), .sel(sel1), .bus_out(bus1), .bus_valid(val1)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_ga, prev_ga;

    // Reset with both requesting.
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; data_a = 4'h5; data_b = 4'hC;
    step();
    chk("rst_grant_a", {3'b0, ga0}, 4'h0);
    chk("rst_grant_b", {3'b0, gb0}, 4'h0);
    chk("rst_sel", {3'b0, sel0}, 4'h0);
    chk("rst_bus_out", bus0, 4'h0);
    chk("rst_bus_valid", {3'b0, val0}, 4'h0);

    // First tie after reset goes to A.
    rst = 1'b0;
    step();
    chk("first_grant_a", {3'b0, ga0}, 4'h1);
    chk("first_grant_b", {3'b0, gb0}, 4'h0);
    chk("first_sel", {3'b0, sel0}, 4'h0);
    chk("first_valid_lag", {3'b0, val0}, 4'h0);
    step();
    chk("first_bus_out", bus0, 4'h5);
    chk("first_bus_valid", {3'b0, val0}, 4'h1);

    // Release to idle.
    req_a = 1'b0; req_b = 1'b0;
    step();
    chk("idle_grant_a", {3'b0, ga0}, 4'h0);
    chk("idle_valid_lag", {3'b0, val0}, 4'h1);
    step();
    chk("idle_valid", {3'b0, val0}, 4'h0);
    chk("idle_bus_hold", bus0, 4'h5);

    // Lone requester B for 20 cycles: no preemption.
    req_b = 1'b1; data_b = 4'hC;
    step();
    for (int i = 0; i < 20; i++) begin
      chk("lone_grant_b", {3'b0, gb0}, 4'h1);
      chk("lone_grant_a", {3'b0, ga0}, 4'h0);
      chk("lone_sel", {3'b0, sel0}, 4'h1);
      if (i > 0) begin
        chk("lone_bus_out", bus0, 4'hC);
        chk("lone_bus_valid", {3'b0, val0}, 4'h1);
      end
      if (i < 19) step();
    end
    req_b = 1'b0;
    step();
    chk("lone_drop_grant", {3'b0, gb0}, 4'h0);
    chk("lone_drop_valid_lag", {3'b0, val0}, 4'h1);
    step();
    chk("lone_drop_valid", {3'b0, val0}, 4'h0);
    chk("idle_sel_hold", {3'b0, sel0}, 4'h1);

    // Contention: blocks of 4 alternating, A first (last owner was B).
    req_a = 1'b1; req_b = 1'b1; data_a = 4'h3; data_b = 4'hA;
    for (int k = 0; k < 16; k++) begin
      step();
      exp_ga  = ((k / 4) % 2) == 0;
      prev_ga = (((k - 1) / 4) % 2) == 0;
      chk("cont_grant_a", {3'b0, ga0}, {3'b0, exp_ga});
      chk("cont_grant_b", {3'b0, gb0}, {3'b0, ~exp_ga});
      chk("cont_sel", {3'b0, sel0}, {3'b0, ~exp_ga});
      if (k > 0) chk("cont_bus_out", bus0, prev_ga ? 4'h3 : 4'hA);
    end

    // Handoff: A granted, B waiting, A drops early -> B with no idle bubble.
    step();
    chk("hand_grant_a0", {3'b0, ga0}, 4'h1);
    step();
    chk("hand_grant_a1", {3'b0, ga0}, 4'h1);
    req_a = 1'b0;
    step();
    chk("hand_grant_b", {3'b0, gb0}, 4'h1);
    chk("hand_valid0", {3'b0, val0}, 4'h1);
    chk("hand_bus0", bus0, 4'h3);
    step();
    chk("hand_valid1", {3'b0, val0}, 4'h1);
    chk("hand_bus1", bus0, 4'hA);

    // Mid-grant reset while B holds with cnt=2.
    req_a = 1'b1;
    step();
    chk("pre_rst_grant_b", {3'b0, gb0}, 4'h1);
    rst = 1'b1;
    step();
    chk("mid_rst_grant_b", {3'b0, gb0}, 4'h0);
    chk("mid_rst_grant_a", {3'b0, ga0}, 4'h0);
    chk("mid_rst_valid", {3'b0, val0}, 4'h0);
    chk("mid_rst_bus", bus0, 4'h0);
    chk("h1_rst_valid", {3'b0, val1}, 4'h0);
    rst = 1'b0;
    step();
    chk("post_rst_grant_a", {3'b0, ga0}, 4'h1);
    chk("h1_first_grant_a", {3'b0, ga1}, 4'h1);
    chk("h1_first_sel", {3'b0, sel1}, 4'h0);

    // HOLD_CYCLES=1: grant and sel alternate every cycle.
    for (int k = 1; k < 7; k++) begin
      step();
      exp_ga = (k % 2) == 0;
      chk("h1_grant_a", {3'b0, ga1}, {3'b0, exp_ga});
      chk("h1_grant_b", {3'b0, gb1}, {3'b0, ~exp_ga});
      chk("h1_sel", {3'b0, sel1}, {3'b0, ~exp_ga});
      chk("h1_bus_out", bus1, exp_ga ? 4'hA : 4'h3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-bit 2:1 mux path between two requesters, A and B.
- Drives the mux select from its grant state and registers the selected data onto a shared output bus with a valid flag.
- A grant lasts while the holder keeps requesting. It is preempted only after HOLD_CYCLES cycles if the other side is waiting.
- Sits between two data producers and a single downstream consumer.

Parameters:
- HOLD_CYCLES, 4, maximum consecutive grant cycles while the other requester waits; legal range 1..15.
- CNT_W, 4, width of the tenure counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_a  in  1  requester A wants the bus; level, held while it needs it
- req_b  in  1  requester B wants the bus; level
- data_a  in  4  requester A data
- data_b  in  4  requester B data
- grant_a  out  1  A owns the bus this cycle; high exactly in state GNT_A
- grant_b  out  1  B owns the bus this cycle; high exactly in state GNT_B
- sel  out  1  mux control: 0 selects data_a, 1 selects data_b
- bus_out  out  4  registered selected data
- bus_valid  out  1  bus_out carries granted data

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst high at a clk edge) forces:
  - state=IDLE, cnt=0, last=B (so A wins the first tie)
  - sel=0, bus_out=4'h0, bus_valid=0
  - Reset overrides all requests and takes effect mid-grant: the grant drops on the next cycle.
- States: IDLE, GNT_A, GNT_B. grant_a and grant_b are decoded from state, are one-hot or both 0, and are never both 1.
- IDLE transitions:
  - req_a & req_b: go to the requester not equal to last.
  - Only req_a: go to GNT_A.
  - Only req_b: go to GNT_B.
  - Neither: stay in IDLE.
- GNT_A transitions (GNT_B is symmetric):
  - !req_a & req_b: go directly to GNT_B; no idle bubble.
  - !req_a & !req_b: go to IDLE.
  - req_a & req_b & cnt==HOLD_CYCLES-1: preempt to GNT_B.
  - Otherwise: stay in GNT_A.
- Tenure counter cnt:
  - Cleared to 0 on every entry into a grant state.
  - Increments each cycle the grant is held.
  - Saturates at HOLD_CYCLES-1 when the other side is not requesting.
  - So a lone requester keeps the grant indefinitely.
- last: updated to the new owner on every entry into a grant state.
- sel:
  - 0 in GNT_A, 1 in GNT_B.
  - In IDLE it holds its previous value, which avoids needless mux toggling.
  - sel is registered alongside state and changes in the same cycle as grant.
- Datapath, evaluated every clk:
  - bus_out <= sel ? data_b : data_a while in a grant state; otherwise it holds its value.
  - bus_valid <= (state != IDLE).
- Latency:
  - req rises at edge n, while in IDLE: grant and sel are visible after edge n+1.
  - The first valid bus_out is visible after edge n+2.
  - After the last grant cycle, bus_valid falls one cycle later.
- Grant length: with both requesting continuously, grants alternate in blocks of exactly HOLD_CYCLES cycles. With HOLD_CYCLES=1 they alternate every cycle.
- Requests are level-sensitive with no acknowledge. Dropping req during a grant releases the bus at the next edge.
- Data changing mid-grant is passed through, with one cycle of latency.

Test Plan:
- Reset: apply rst with req_a=req_b=1 -> all outputs 0; after release, first grant goes to A (grant_a=1 one cycle later); bus_out=data_a=4'h5 the following cycle with bus_valid=1.
- Lone requester: req_b=1 for 20 cycles, data_b=4'hC -> grant_b stays high 20 cycles (no preemption), sel=1, bus_out=4'hC throughout; req_b drops -> IDLE next cycle, bus_valid falls one cycle after that.
- Contention, HOLD_CYCLES=4: req_a=req_b=1 steady, data_a=4'h3, data_b=4'hA -> grant pattern A×4, B×4, A×4…; bus_out lags by one cycle: 3,3,3,3,A,A,A,A.
- Handoff: A granted, B requesting, req_a drops before cnt expires -> GNT_B on the next edge with no IDLE cycle; bus_valid stays high continuously.
- Mid-grant reset: rst pulsed for 1 cycle during GNT_B with cnt=2 -> next cycle grant_b=0, bus_valid=0, bus_out=0; with both still requesting, A wins (last=B).
- HOLD_CYCLES=1 build: both request -> grant alternates A,B,A,B every cycle and sel toggles every cycle.
